// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and latency defaults for the HI/LO unit scheduler.
`default_nettype none

package md_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'd0;
  localparam logic [1:0] MD_OP_MULTU = 2'd1;
  localparam logic [1:0] MD_OP_DIV   = 2'd2;
  localparam logic [1:0] MD_OP_DIVU  = 2'd3;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;
  localparam int MD_CNT_W    = 4;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic md_op_is_div(input logic [1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_lat_counter.sv
// Load / decrement / zero-detect latency counter; saturates at zero instead of wrapping.
`default_nettype none

module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_one,
  output logic             o_is_zero
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over decrement so a back-to-back op reloads on the final busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_one  = (r_cnt == c_one);
  assign o_is_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/md_stall_ctrl.sv
// HI/LO unit occupancy tracker and F/D stall / E flush generator.
// Optional MD_EARLY_RELEASE_EN: releases mfhi/mflo in the final busy cycle.
`default_nettype none

module md_stall_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT,
  parameter int CNT_W    = MD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_md_start,
  input  logic [1:0]       E_md_op,
  input  logic             D_md_use,
  input  logic             D_md_read,
  input  logic             hz_stall,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_E,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] md_cnt
);

  localparam logic [CNT_W-1:0] c_mult_lat = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] c_div_lat  = CNT_W'(DIV_LAT);

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic             w_load;
  logic             w_dec;
  logic             w_done;
  logic             w_cnt_one;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_load_val;
  logic             w_busy;
  logic             w_md_stall;
  logic             w_stall;

  assign w_load_val = md_op_is_div(E_md_op) ? c_div_lat : c_mult_lat;

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_is_one   (w_cnt_one),
    .o_is_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (E_md_start) begin
          w_load       = 1'b1;
          w_state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (w_cnt_zero) begin
          // Unreachable in normal operation; recover rather than hang busy.
          w_state_next = MD_IDLE;
        end else begin
          w_dec = 1'b1;
          if (w_cnt_one) begin
            w_done = 1'b1;
            if (E_md_start) begin
              w_load = 1'b1;
            end else begin
              w_state_next = MD_IDLE;
            end
          end
        end
      end
      default: w_state_next = MD_IDLE;
    endcase
  end

  assign w_busy = (r_state == MD_BUSY);

`ifdef MD_EARLY_RELEASE_EN
  // HI/LO is written at the closing edge, so a read in D may advance into E alongside it.
  assign w_md_stall = D_md_use & (E_md_start | (w_busy & ~(w_done & D_md_read)));
`else
  assign w_md_stall = D_md_use & (E_md_start | w_busy);
`endif

  assign w_stall = w_md_stall | hz_stall;
  assign stall_F = w_stall;
  assign stall_D = w_stall;
  assign flush_E = w_stall;
  assign md_busy = w_busy;
  assign md_done = w_done;
  assign md_cnt  = w_cnt;

endmodule

`default_nettype wire
